line_streamer: RTL and testbench

LINE_STREAMER -- requirements
Module: line_streamer

---
 rtl/streamer_pkg.sv | 25 ++
 rtl/pair_fifo.sv | 50 +++++
 rtl/line_streamer.sv | 139 +++++++++++++
 tb/tb_line_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/streamer_pkg.sv
// Shared definitions for the line streamer: FSM encoding and helpers that
// split a packed {line_len, line_start} pointer word into its fields.
package streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int PTR_MAX_W = 64;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t field_mask(input int w);
    return (ptr_word_t'(1) << w) - ptr_word_t'(1);
  endfunction

  function automatic ptr_word_t ptr_start(input ptr_word_t ptr, input int addr_w);
    return ptr & field_mask(addr_w);
  endfunction

  function automatic ptr_word_t ptr_len(input ptr_word_t ptr, input int addr_w, input int len_w);
    return (ptr >> addr_w) & field_mask(len_w);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small circular buffer holding returned {lhs, rhs} character pairs until the
// consumer accepts them. DEPTH need not be a power of two.
module pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] cnt;

  function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_idx <= bump(wr_idx);
      if (pop)  rd_idx <= bump(rd_idx);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_idx] <= din;
  end

  assign dout  = slots[rd_idx];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/line_streamer.sv
// Streams one line of character pairs from a read-latency memory to a
// valid/ready sink, throttling reads so the return buffer can never overflow.
module line_streamer
  import streamer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int CHAR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W+ADDR_W-1:0] pointer_addr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_en,
  input  logic [2*CHAR_W-1:0]     mem_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHAR_W-1:0]       out_lhs,
  output logic [CHAR_W-1:0]       out_rhs,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_W-1:0]        chars_remaining
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   req_start, rd_addr, last_addr;
  logic [LEN_W-1:0]    req_len, reads_left, remaining;
  logic [RD_LAT-1:0]   vld_p;
  logic                done_r, launch, finish, accept_idle;
  logic                fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [2*CHAR_W-1:0] fifo_dout;
  logic [OCC_W-1:0]    in_flight, committed;

  assign req_start   = ADDR_W'(ptr_start(ptr_word_t'(pointer_addr), ADDR_W));
  assign req_len     = LEN_W'(ptr_len(ptr_word_t'(pointer_addr), ADDR_W, LEN_W));
  assign accept_idle = (state == ST_IDLE) && start && !abort;
  assign launch      = accept_idle && (req_len != '0);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + OCC_W'(vld_p[i]);
  end

  // A beat leaving this cycle frees its slot, which keeps full throughput.
  assign fifo_pop  = out_valid && out_ready;
  assign committed = in_flight + OCC_W'(fifo_count) - OCC_W'(fifo_pop);
  assign fifo_push = vld_p[RD_LAT-1];
  assign fifo_clr  = (state == ST_STREAM) && abort;

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          mem_en = (reads_left != '0) && (committed < OCC_W'(DEPTH));
          finish = fifo_pop && (remaining == LEN_W'(1));
          if (finish) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Control stage: in-flight tracking, counters, completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p      <= '0;
      remaining  <= '0;
      reads_left <= '0;
      done_r     <= 1'b0;
      last_addr  <= '1;
    end else begin
      done_r <= finish || (accept_idle && (req_len == '0));
      if (mem_en) last_addr <= rd_addr;
      if (fifo_clr) vld_p <= '0;
      else          vld_p <= (vld_p << 1) | RD_LAT'(mem_en);
      if (launch)        remaining <= req_len;
      else if (fifo_clr) remaining <= '0;
      else if (fifo_pop) remaining <= remaining - LEN_W'(1);
      if (launch)        reads_left <= req_len;
      else if (fifo_clr) reads_left <= '0;
      else if (mem_en)   reads_left <= reads_left - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (launch)      rd_addr <= req_start;
    else if (mem_en) rd_addr <= rd_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_full && fifo_push && !fifo_pop && !fifo_clr));
  end

  pair_fifo #(
    .WIDTH (2 * CHAR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_dout),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_addr        = mem_en ? rd_addr : last_addr;
  assign out_valid       = (state == ST_STREAM) && !fifo_empty;
  assign out_last        = out_valid && (remaining == LEN_W'(1));
  assign out_lhs         = fifo_dout[2*CHAR_W-1:CHAR_W];
  assign out_rhs         = fifo_dout[CHAR_W-1:0];
  assign busy            = (state == ST_STREAM);
  assign done            = done_r;
  assign chars_remaining = remaining;

endmodule

// File: tb/tb_line_streamer.sv
// Bench for line_streamer: two instances (read latency 1 and 3) share stimulus;
// a line-level model checks every cycle, plus directed literal timing checks.
module tb_line_streamer;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic [19:0] pointer_addr;

  logic [9:0]  ma0, ma1, rem0, rem1;
  logic        en0, en1, ov0, ov1, last0, last1, b0, b1, d0, d1;
  logic [7:0]  lhs0, rhs0, lhs1, rhs1;
  logic [15:0] dout0, dout1;

  logic [15:0] mem_arr [1024];
  logic [15:0] pipe0;
  logic [15:0] pipe1 [3];

  int vectors = 0, miscompares = 0, cyc = 0;
  int rmode = 0, ph = 0;
  bit stray = 0;

  bit          m_busy [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_stall[2] = '{0, 0};
  int          m_len  [2], m_base[2], m_iss[2], m_xfr[2];
  int          m_rem  [2] = '{0, 0};
  int          hs_cnt [2] = '{0, 0};
  int          depth  [2] = '{2, 4};
  logic [9:0]  m_last [2] = '{10'h3FF, 10'h3FF};
  logic [15:0] m_hold [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_streamer #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pointer_addr(pointer_addr),
    .mem_addr(ma0), .mem_en(en0), .mem_dout(dout0), .out_valid(ov0), .out_ready(out_ready),
    .out_lhs(lhs0), .out_rhs(rhs0), .out_last(last0), .busy(b0), .done(d0),
    .chars_remaining(rem0));

  line_streamer #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8), .RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pointer_addr(pointer_addr),
    .mem_addr(ma1), .mem_en(en1), .mem_dout(dout1), .out_valid(ov1), .out_ready(out_ready),
    .out_lhs(lhs1), .out_rhs(rhs1), .out_last(last1), .busy(b1), .done(d1),
    .chars_remaining(rem1));

  // Memory: data for a read appears RD_LAT cycles later; garbage otherwise
  always @(posedge clk) begin
    pipe0    <= en0 ? mem_arr[ma0] : 16'($urandom);
    pipe1[0] <= en1 ? mem_arr[ma1] : 16'($urandom);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign dout0 = pipe0;
  assign dout1 = pipe1[2];

  task automatic expect_eq(input string name, input int k, input logic [63:0] act,
                           input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[u%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic chk(input int k, input logic en, input logic [9:0] addr, input logic ov,
                     input logic [15:0] data, input logic last, input logic bsy,
                     input logic dn, input logic [9:0] rem);
    int idx;
    bit nd;
    expect_eq("busy", k, bsy, m_busy[k]);
    expect_eq("done", k, dn, m_done[k]);
    expect_eq("chars_remaining", k, rem, m_rem[k]);
    if (!en) expect_eq("mem_addr_hold", k, addr, m_last[k]);
    if (!m_busy[k]) begin
      expect_eq("idle_mem_en", k, en, 0);
      expect_eq("idle_out_valid", k, ov, 0);
    end else begin
      if (en) begin
        expect_eq("read_within_len", k, m_iss[k] < m_len[k], 1);
        expect_eq("mem_addr", k, addr, (m_base[k] + m_iss[k]) % 1024);
      end
      if (ov) begin
        idx = (m_base[k] + m_xfr[k]) % 1024;
        expect_eq("beat_within_len", k, m_xfr[k] < m_len[k], 1);
        expect_eq("beat_data", k, data, mem_arr[idx]);
        expect_eq("out_last", k, last, m_xfr[k] == m_len[k] - 1);
      end
      if (m_stall[k]) begin
        expect_eq("stall_valid", k, ov, 1);
        expect_eq("stall_data", k, data, m_hold[k]);
      end
      expect_eq("occupancy", k, (m_iss[k] - m_xfr[k]) <= depth[k], 1);
    end
    // Advance the model with this cycle's inputs and handshakes
    if (ov && out_ready) hs_cnt[k]++;
    nd = 0;
    m_stall[k] = 0;
    if (rst) begin
      m_busy[k] = 0;
      m_rem[k]  = 0;
      m_last[k] = 10'h3FF;
    end else begin
      if (en) m_last[k] = addr;
      if (!m_busy[k]) begin
        if (start && !abort) begin
          if (pointer_addr[19:10] == 10'd0) nd = 1;
          else begin
            m_busy[k] = 1;
            m_len[k]  = int'(pointer_addr[19:10]);
            m_base[k] = int'(pointer_addr[9:0]);
            m_rem[k]  = m_len[k];
            m_iss[k]  = 0;
            m_xfr[k]  = 0;
          end
        end
      end else if (abort) begin
        m_busy[k] = 0;
        m_rem[k]  = 0;
      end else begin
        if (en) m_iss[k]++;
        if (ov && out_ready) begin
          m_xfr[k]++;
          m_rem[k]--;
          if (m_xfr[k] == m_len[k]) begin
            m_busy[k] = 0;
            nd = 1;
          end
        end else if (ov) begin
          m_stall[k] = 1;
          m_hold[k]  = data;
        end
      end
    end
    m_done[k] = nd;
  endtask

  always @(negedge clk) begin
    chk(0, en0, ma0, ov0, {lhs0, rhs0}, last0, b0, d0, rem0);
    chk(1, en1, ma1, ov1, {lhs1, rhs1}, last1, b1, d1, rem1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = $urandom_range(0, 1) != 0;
    endcase
    ph++;
    if (stray) begin
      abort = ($urandom_range(0, 39) == 0);
      start = b0 && b1 && ($urandom_range(0, 5) == 0);
      if (start) pointer_addr = 20'($urandom);
    end
  endtask

  task automatic launch(input logic [9:0] base, input logic [9:0] len);
    start = 1'b1;
    pointer_addr = {len, base};
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!b0 && !b1 && !d0 && !d1) begin
        ok = 1;
        break;
      end
      cycle();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", maxc);
    end
    cycle();
  endtask

  logic [9:0] e_addr0 [1:7];
  logic [9:0] e_wrap  [1:4];
  bit   [7:1] e_en0, e_ov0, e_last0, e_done0, e_busy0, e_ov1;
  int h0, h1;

  initial begin
    for (int a = 0; a < 1024; a++) mem_arr[a] = 16'($urandom);
    e_addr0 = '{10'h010, 10'h011, 10'h012, 10'h012, 10'h012, 10'h012, 10'h020};
    e_wrap  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    e_en0   = 7'b1000111;
    e_ov0   = 7'b0011100;
    e_last0 = 7'b0010000;
    e_done0 = 7'b0100000;
    e_busy0 = 7'b1011111;
    e_ov1   = 7'b1110000;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; pointer_addr = '0;
    repeat (3) cycle();
    @(negedge clk);
    expect_eq("rst_mem_addr", 0, ma0, 10'h3FF);
    expect_eq("rst_mem_addr", 1, ma1, 10'h3FF);
    expect_eq("rst_state", 0, {en0, ov0, last0, b0, d0}, 5'b0);
    expect_eq("rst_state", 1, {en1, ov1, last1, b1, d1}, 5'b0);
    cycle();
    rst = 1'b0;

    // len=3 at 0x010, then a new start accepted in the done cycle
    start = 1'b1;
    pointer_addr = {10'd3, 10'h010};
    for (int c = 1; c <= 7; c++) begin
      cycle();
      if (c == 1) start = 1'b0;
      if (c == 6) begin
        start = 1'b1;
        pointer_addr = {10'd1, 10'h020};
      end
      if (c == 7) start = 1'b0;
      @(negedge clk);
      expect_eq("t_mem_en", 0, en0, e_en0[c]);
      expect_eq("t_mem_addr", 0, ma0, e_addr0[c]);
      expect_eq("t_out_valid", 0, ov0, e_ov0[c]);
      expect_eq("t_out_last", 0, last0, e_last0[c]);
      expect_eq("t_done", 0, d0, e_done0[c]);
      expect_eq("t_busy", 0, b0, e_busy0[c]);
      expect_eq("t_out_valid", 1, ov1, e_ov1[c]);
      if (c == 1) expect_eq("t_rem_load", 0, rem0, 10'd3);
    end
    wait_idle(60);

    // Zero-length line
    launch(10'h155, 10'd0);
    @(negedge clk);
    expect_eq("len0_done", 0, d0, 1);
    expect_eq("len0_done", 1, d1, 1);
    expect_eq("len0_quiet", 0, {en0, ov0, b0}, 3'b0);
    expect_eq("len0_quiet", 1, {en1, ov1, b1}, 3'b0);
    cycle();

    // Abort and start together in idle: nothing starts
    abort = 1'b1;
    launch(10'h100, 10'd5);
    abort = 1'b0;
    @(negedge clk);
    expect_eq("abort_prio_busy", 0, b0, 0);
    expect_eq("abort_prio_busy", 1, b1, 0);
    expect_eq("abort_prio_done", 0, d0, 0);
    cycle();

    // Address wrap
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    start = 1'b1;
    pointer_addr = {10'd4, 10'h3FE};
    for (int c = 1; c <= 4; c++) begin
      cycle();
      start = 1'b0;
      @(negedge clk);
      expect_eq("wrap_mem_en", 0, en0, 1);
      expect_eq("wrap_mem_addr", 0, ma0, e_wrap[c]);
    end
    wait_idle(60);
    expect_eq("wrap_beats", 0, hs_cnt[0] - h0, 4);
    expect_eq("wrap_beats", 1, hs_cnt[1] - h1, 4);

    // Ready pattern 1,0,0,1 with len=8
    rmode = 1; ph = 0;
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    launch(10'h200, 10'd8);
    wait_idle(200);
    expect_eq("pattern_beats", 0, hs_cnt[0] - h0, 8);
    expect_eq("pattern_beats", 1, hs_cnt[1] - h1, 8);

    // Abort after the second beat, then a fresh line
    rmode = 0;
    h0 = hs_cnt[0];
    launch(10'h080, 10'd6);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs_cnt[0] - h0 >= 2) break;
      cycle();
    end
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    @(negedge clk);
    expect_eq("abort_busy", 0, b0, 0);
    expect_eq("abort_busy", 1, b1, 0);
    expect_eq("abort_rem", 0, rem0, 0);
    expect_eq("abort_quiet", 0, {ov0, d0}, 2'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      @(negedge clk);
      expect_eq("post_abort_quiet", 0, {ov0, d0}, 2'b0);
      expect_eq("post_abort_quiet", 1, {ov1, d1}, 2'b0);
    end
    cycle();
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    launch(10'h090, 10'd2);
    wait_idle(60);
    expect_eq("after_abort_beats", 0, hs_cnt[0] - h0, 2);
    expect_eq("after_abort_beats", 1, hs_cnt[1] - h1, 2);

    // Reset mid-line with reads in flight
    rmode = 2;
    launch(10'h300, 10'd10);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    expect_eq("midrst_mem_addr", 0, ma0, 10'h3FF);
    expect_eq("midrst_mem_addr", 1, ma1, 10'h3FF);
    expect_eq("midrst_state", 0, {en0, ov0, last0, b0, d0, rem0}, 15'b0);
    expect_eq("midrst_state", 1, {en1, ov1, last1, b1, d1, rem1}, 15'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      @(negedge clk);
      expect_eq("post_rst_quiet", 1, ov1, 0);
    end
    cycle();
    h0 = hs_cnt[0]; h1 = hs_cnt[1];
    launch(10'h310, 10'd3);
    wait_idle(100);
    expect_eq("after_rst_beats", 0, hs_cnt[0] - h0, 3);
    expect_eq("after_rst_beats", 1, hs_cnt[1] - h1, 3);

    // Randomized lines, ready patterns, stray starts and aborts
    for (int n = 0; n < 30; n++) begin
      rmode = $urandom_range(0, 3);
      stray = (n % 2) == 1;
      launch(10'($urandom), 10'($urandom_range(0, 24)));
      wait_idle(600);
      stray = 1'b0;
      abort = 1'b0;
      start = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
